// File: rtl/gray_tracker_if.sv
// Bundle between the Gray step-counter consumer and its sampling/test side.
// The master drives the sampled counter and soft clear; the slave returns the tracking results.
interface gray_tracker_if #(
    parameter int CW = 8,
    parameter int WW = 4
);
    logic          Clear;
    logic [2:0]    Gray;
    logic          Overflow;
    logic [2:0]    Bin;
    logic [CW-1:0] Count;
    logic [WW-1:0] Wraps;
    logic          Step;
    logic          UpRst;
    logic          Error;
    logic [2:0]    ErrGray;

    modport master (
        output Clear, Gray, Overflow,
        input  Bin, Count, Wraps, Step, UpRst, Error, ErrGray
    );

    modport slave (
        input  Clear, Gray, Overflow,
        output Bin, Count, Wraps, Step, UpRst, Error, ErrGray
    );
endinterface

// File: rtl/gray_tracker.sv
// Tracks a 3-bit Gray step counter: converts it to binary, counts legal steps and wraps,
// recognises upstream resets and latches the first illegal transition as a sticky fault.
module gray_tracker #(
    parameter int CW = 8,
    parameter int WW = 4
) (
    input logic          Clk,
    input logic          Reset,
    gray_tracker_if.slave bus
);
    typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

    state_t        state, state_nxt;
    logic [2:0]    bin, bin_nxt;
    logic          prev_ovf, prev_ovf_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [WW-1:0] wraps, wraps_nxt;
    logic          step, step_nxt;
    logic          uprst, uprst_nxt;
    logic          error, error_nxt;
    logic [2:0]    err_gray, err_gray_nxt;

    logic [2:0]    n;
    logic [2:0]    bin_inc;
    logic          ovf;
    logic          is_hold, is_uprst, is_wrap, step_ok;

    function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [CW-1:0] sat_inc_count(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    function automatic logic [WW-1:0] sat_inc_wraps(input logic [WW-1:0] v);
        return (&v) ? v : v + WW'(1);
    endfunction

    // bin doubles as the previous-sample binary: both only move on non-fault cycles
    always_comb begin
        n        = gray_to_bin(bus.Gray);
        ovf      = bus.Overflow;
        bin_inc  = bin + 3'd1;
        is_wrap  = (bin == 3'd7);
        is_hold  = (n == bin) && (ovf == prev_ovf);
        // the only path on which Overflow may legally fall
        is_uprst = (n == 3'd0) && !ovf && (!is_wrap || prev_ovf);
        step_ok  = (n == bin_inc) && (is_wrap ? ovf : (ovf == prev_ovf));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)          state <= SYNC;
        else if (bus.Clear) state <= SYNC;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:    state_nxt = TRACK;
            TRACK:   if (!is_hold && !is_uprst && !step_ok) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = SYNC;
        endcase
    end

    always_comb begin
        bin_nxt      = bin;
        prev_ovf_nxt = prev_ovf;
        count_nxt    = count;
        wraps_nxt    = wraps;
        step_nxt     = 1'b0;
        uprst_nxt    = 1'b0;
        error_nxt    = error;
        err_gray_nxt = err_gray;
        case (state)
            SYNC: begin
                bin_nxt      = n;
                prev_ovf_nxt = ovf;
            end
            TRACK: begin
                if (is_hold) begin
                    bin_nxt = n;
                end else if (is_uprst) begin
                    bin_nxt      = n;
                    prev_ovf_nxt = ovf;
                    uprst_nxt    = 1'b1;
                end else if (step_ok) begin
                    bin_nxt      = n;
                    prev_ovf_nxt = ovf;
                    step_nxt     = 1'b1;
                    count_nxt    = sat_inc_count(count);
                    if (is_wrap) wraps_nxt = sat_inc_wraps(wraps);
                end else begin
                    error_nxt    = 1'b1;
                    err_gray_nxt = bus.Gray;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset || bus.Clear) begin
            bin      <= '0;
            prev_ovf <= 1'b0;
            count    <= '0;
            wraps    <= '0;
            step     <= 1'b0;
            uprst    <= 1'b0;
            error    <= 1'b0;
            err_gray <= '0;
        end else begin
            bin      <= bin_nxt;
            prev_ovf <= prev_ovf_nxt;
            count    <= count_nxt;
            wraps    <= wraps_nxt;
            step     <= step_nxt;
            uprst    <= uprst_nxt;
            error    <= error_nxt;
            err_gray <= err_gray_nxt;
        end
    end

    assign bus.Bin     = bin;
    assign bus.Count   = count;
    assign bus.Wraps   = wraps;
    assign bus.Step    = step;
    assign bus.UpRst   = uprst;
    assign bus.Error   = error;
    assign bus.ErrGray = err_gray;
endmodule

// File: tb/tb_gray_tracker.sv
// Scoreboard bench for gray_tracker: a CW=8 and a CW=3 instance see identical stimulus;
// directed vectors queue their expected outputs and a monitor compares after each edge.
module tb_gray_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_tracker_if #(.CW(8), .WW(4)) bus8 ();
    gray_tracker_if #(.CW(3), .WW(4)) bus3 ();

    gray_tracker #(.CW(8), .WW(4)) dut8 (.Clk(clk), .Reset(rst), .bus(bus8));
    gray_tracker #(.CW(3), .WW(4)) dut3 (.Clk(clk), .Reset(rst), .bus(bus3));

    typedef struct {
        int         id;
        logic [2:0] bin;
        int         cnt;
        int         wr;
        logic       st;
        logic       up;
        logic       err;
        logic [2:0] eg;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vid   = 0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [2:0] g_of(input int v);
        return 3'(v ^ (v >> 1));
    endfunction

    function automatic logic [20:0] pk(input logic [2:0] b, input logic [7:0] c, input logic [3:0] w,
                                       input logic s, input logic u, input logic e, input logic [2:0] g);
        return {b, c, w, s, u, e, g};
    endfunction

    task automatic chk(input string name, input logic [20:0] got, input logic [20:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got bin=%0d cnt=%0d wraps=%0d step=%b uprst=%b err=%b errgray=%b, want bin=%0d cnt=%0d wraps=%0d step=%b uprst=%b err=%b errgray=%b",
                     name, got[20:18], got[17:10], got[9:6], got[5], got[4], got[3], got[2:0],
                     want[20:18], want[17:10], want[9:6], want[5], want[4], want[3], want[2:0]);
        end
    endtask

    function automatic logic [20:0] out8();
        return pk(bus8.Bin, bus8.Count, bus8.Wraps, bus8.Step, bus8.UpRst, bus8.Error, bus8.ErrGray);
    endfunction

    function automatic logic [20:0] out3();
        return pk(bus3.Bin, {5'b0, bus3.Count}, bus3.Wraps, bus3.Step, bus3.UpRst, bus3.Error, bus3.ErrGray);
    endfunction

    task automatic drive(input logic [2:0] g, input logic o, input logic c);
        bus8.Gray = g; bus8.Overflow = o; bus8.Clear = c;
        bus3.Gray = g; bus3.Overflow = o; bus3.Clear = c;
    endtask

    task automatic push(input logic [2:0] b, input int cnt, input int wr, input logic st,
                        input logic up, input logic err, input logic [2:0] eg);
        exp_t e;
        e.id = vid; e.bin = b; e.cnt = cnt; e.wr = wr; e.st = st; e.up = up; e.err = err; e.eg = eg;
        vid++;
        q.push_back(e);
    endtask

    task automatic vec(input logic [2:0] g, input logic o, input logic c, input logic [2:0] b, input int cnt,
                       input int wr, input logic st, input logic up, input logic err, input logic [2:0] eg);
        @(negedge clk);
        drive(g, o, c);
        push(b, cnt, wr, st, up, err, eg);
    endtask

    // Monitor: one expected entry per clock edge while the scoreboard holds any
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk($sformatf("v%0d_cw8", e.id), out8(),
                    pk(e.bin, 8'(sat(e.cnt, 255)), 4'(sat(e.wr, 15)), e.st, e.up, e.err, e.eg));
                chk($sformatf("v%0d_cw3", e.id), out3(),
                    pk(e.bin, 8'(sat(e.cnt, 7)), 4'(sat(e.wr, 15)), e.st, e.up, e.err, e.eg));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   nb;
        int   c;
        int   w;
        logic o;

        drive(3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_state_cw8", out8(), 21'd0);
        chk("reset_state_cw3", out3(), 21'd0);
        rst = 1'b0;
        push(3'd0, 0, 0, 0, 0, 0, 3'b000);                     // SYNC baseline

        // Forward sequence 0..6, a hold, then 7 and a wrap with Overflow
        vec(3'b001, 0, 0, 3'd1, 1, 0, 1, 0, 0, 3'b000);
        vec(3'b011, 0, 0, 3'd2, 2, 0, 1, 0, 0, 3'b000);
        vec(3'b010, 0, 0, 3'd3, 3, 0, 1, 0, 0, 3'b000);
        vec(3'b110, 0, 0, 3'd4, 4, 0, 1, 0, 0, 3'b000);
        vec(3'b111, 0, 0, 3'd5, 5, 0, 1, 0, 0, 3'b000);
        vec(3'b101, 0, 0, 3'd6, 6, 0, 1, 0, 0, 3'b000);
        vec(3'b101, 0, 0, 3'd6, 6, 0, 0, 0, 0, 3'b000);
        vec(3'b100, 0, 0, 3'd7, 7, 0, 1, 0, 0, 3'b000);
        vec(3'b000, 1, 0, 3'd0, 8, 1, 1, 0, 0, 3'b000);
        vec(3'b000, 1, 0, 3'd0, 8, 1, 0, 0, 0, 3'b000);
        vec(3'b000, 0, 0, 3'd0, 8, 1, 0, 1, 0, 3'b000);         // upstream reset
        vec(3'b000, 0, 0, 3'd0, 8, 1, 0, 0, 0, 3'b000);

        // Jump 2 -> 4 faults; later legal steps are ignored until Clear
        vec(3'b001, 0, 0, 3'd1, 9, 1, 1, 0, 0, 3'b000);
        vec(3'b011, 0, 0, 3'd2, 10, 1, 1, 0, 0, 3'b000);
        vec(3'b110, 0, 0, 3'd2, 10, 1, 0, 0, 1, 3'b110);
        vec(3'b010, 0, 0, 3'd2, 10, 1, 0, 0, 1, 3'b110);
        vec(3'b110, 0, 0, 3'd2, 10, 1, 0, 0, 1, 3'b110);
        vec(3'b110, 0, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);         // Clear

        // Overflow rising on a non-wrap step
        vec(3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'b000);
        vec(3'b001, 0, 0, 3'd1, 1, 0, 1, 0, 0, 3'b000);
        vec(3'b011, 1, 0, 3'd1, 1, 0, 0, 0, 1, 3'b011);
        vec(3'b011, 0, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);

        // Wrap 7 -> 0 without Overflow
        vec(3'b100, 0, 0, 3'd7, 0, 0, 0, 0, 0, 3'b000);
        vec(3'b000, 0, 0, 3'd7, 0, 0, 0, 0, 1, 3'b000);
        vec(3'b000, 0, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);

        // Backward step
        vec(3'b011, 0, 0, 3'd2, 0, 0, 0, 0, 0, 3'b000);
        vec(3'b001, 0, 0, 3'd2, 0, 0, 0, 0, 1, 3'b001);
        vec(3'b001, 1, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);

        // Upstream reset from 7 with Overflow set, then Overflow rising with no wrap
        vec(3'b100, 1, 0, 3'd7, 0, 0, 0, 0, 0, 3'b000);
        vec(3'b000, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'b000);
        vec(3'b000, 1, 0, 3'd0, 0, 0, 0, 0, 1, 3'b000);
        vec(3'b000, 0, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);

        // 160 legal steps: 20 wraps, CW=3 count saturates, Step keeps pulsing
        vec(3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'b000);
        nb = 0; c = 0; w = 0; o = 1'b0;
        for (int i = 0; i < 160; i++) begin
            nb = (nb + 1) % 8;
            if (nb == 0) begin
                w++;
                o = 1'b1;
            end
            c++;
            vec(g_of(nb), o, 0, 3'(nb), c, w, 1, 0, 0, 3'b000);
        end
        vec(3'b000, 1, 1, 3'd0, 0, 0, 0, 0, 0, 3'b000);

        // Asynchronous reset between edges with Count=5
        vec(3'b000, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'b000);
        vec(3'b001, 0, 0, 3'd1, 1, 0, 1, 0, 0, 3'b000);
        vec(3'b011, 0, 0, 3'd2, 2, 0, 1, 0, 0, 3'b000);
        vec(3'b010, 0, 0, 3'd3, 3, 0, 1, 0, 0, 3'b000);
        vec(3'b110, 0, 0, 3'd4, 4, 0, 1, 0, 0, 3'b000);
        vec(3'b111, 0, 0, 3'd5, 5, 0, 1, 0, 0, 3'b000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_cw8", out8(), 21'd0);
        chk("async_reset_cw3", out3(), 21'd0);
        @(negedge clk);
        drive(3'b110, 1'b0, 1'b0);
        rst = 1'b0;
        push(3'd4, 0, 0, 0, 0, 0, 3'b000);                      // SYNC on Gray 110
        vec(3'b111, 0, 0, 3'd5, 1, 0, 1, 0, 0, 3'b000);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 21'(q.size()), 21'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_tracker.md
Name: gray_tracker

Overview:
Downstream consumer of the 3-bit Gray step counter. Samples the counter's Gray output and Overflow flag every cycle and converts Gray to binary. It checks that every change is a legal single-step advance, counts valid steps and wrap-arounds, and latches the first illegal transition as a fault. It gives the CPU-side test logic a binary view plus an integrity check of the Gray sequence.

Parameters:
CW, 8, width of valid-step counter Count
WW, 4, width of wrap counter Wraps

Ports:
Clk  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-high; clears all state immediately
Clear  input  1  synchronous soft clear; same effect as Reset but on the clock edge
Gray  input  3  Gray code from upstream counter (000,001,011,010,110,111,101,100 cycle)
Overflow  input  1  upstream sticky overflow flag
Bin  output  3  registered binary equivalent of last sampled Gray
Count  output  CW  number of valid +1 steps since reset/clear, saturating
Wraps  output  WW  number of valid 7->0 wraps, saturating
Step  output  1  one-cycle pulse on each valid step
UpRst  output  1  one-cycle pulse when an upstream reset is recognised
Error  output  1  sticky fault flag
ErrGray  output  3  Gray value that caused the first fault

Behaviour:
- Reset (async) or Clear (sync, has priority over all other activity):
  - state=SYNC.
  - Bin=0, Count=0, Wraps=0, Step=0, UpRst=0, Error=0, ErrGray=0.
  - Previous-sample registers: prevBin=0, prevOvf=0.
- Gray->binary conversion: b2=g2, b1=g2^g1, b0=g2^g1^g0.
- Bin is updated every cycle in SYNC and TRACK, giving 1-cycle latency from Gray; Bin is frozen in FAULT.
- States:
  - SYNC: first edge captures Gray/Overflow as the baseline (prevBin, prevOvf, Bin). No counting and no error. Next state is TRACK.
  - TRACK: let n = binary of sampled Gray; evaluate in this priority order:
    1. n == prevBin and Overflow == prevOvf: hold; Step=0.
    2. Upstream reset: n==0, Overflow==0, and (prevBin!=7 or prevOvf==1).
       - UpRst=1; baseline updated; Count and Wraps unchanged; no error.
       - This is the only legal way Overflow may fall.
    3. Valid step: n == prevBin+1 (mod 8).
       - Step=1; Count+1, saturating at 2^CW-1.
       - If prevBin==7 (wrap): Wraps+1, saturating at 2^WW-1. Overflow must read 1 on this same sample; Overflow staying 0 on the wrap is illegal.
       - On a non-wrap step, Overflow must equal prevOvf.
    4. Anything else is a fault: Error=1, ErrGray=Gray, state=FAULT. Covers multi-bit jumps, backward steps, and Overflow rising without a wrap.
    - prevBin/prevOvf update on every non-fault cycle.
- FAULT:
  - All outputs hold; Step and UpRst are 0.
  - Exits only via Reset or Clear, which go to SYNC.
- Step and UpRst are registered single-cycle pulses, never high together.
- Saturation: at max, Count/Wraps stay at max; Step still pulses.
- Reset asserted mid-sequence: outputs go to 0 without waiting for Clk. After release, the first edge is SYNC, so whatever value upstream holds becomes the baseline without error.

Test Plan:
- Reset, then feed 000,001,011,010,110,111,101 -> after SYNC: Bin tracks 0..6 one cycle late, Count=6, Step pulses 6 times, Error=0.
- Continue with 100, then 000 with Overflow=1 -> Count=8, Wraps=1, Error=0. Then an upstream reset (Gray=000, Overflow=0) -> UpRst pulse, Count=8 unchanged.
- From Bin=2 (Gray 011), apply Gray 110 -> Error=1, ErrGray=110, Bin stays 2. Subsequent legal steps leave Count frozen. Clear -> all zero, SYNC.
- Wrap 100->000 while Overflow stays 0 -> Error=1, ErrGray=000. Separately, Overflow rising during 001->011 -> Error=1.
- CW=3: run 9 valid steps -> Count saturates at 7, ninth Step still pulses. WW=4: 20 wraps -> Wraps=15.
- Assert Reset asynchronously between edges with Count=5 -> Count=0 before the next posedge. Release with Gray=110 -> first edge SYNC, Bin=4, no Error. Next Gray 111 -> Count=1.
